// File: rtl/pll_lock_supervisor_pkg.sv
// PLL lock supervisor shared types: state encoding and timer width helpers.
// Imported by the interface, the synchronizer and the top.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } pll_sup_state_t;

    // Bits needed to hold a count up to and including n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // One shared timer serves all phases, so it is as wide as the largest one.
    function automatic int tmr_w(input int a, input int b, input int c);
        int w;
        w = cnt_w(a);
        if (cnt_w(b) > w) w = cnt_w(b);
        if (cnt_w(c) > w) w = cnt_w(c);
        return w;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL/reset-tree side bundle of the lock supervisor.
// master: the supervisor (drives pll_rst, sys_reset_n, status); slave: PLL + environment.
interface pll_sup_if;
    import pll_sup_pkg::*;

    logic       req_relock;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  req_relock, pll_locked,
        output pll_rst, sys_reset_n, ready, fault,
        output retry_cnt, state_dbg, lock_loss_cnt
    );

    modport slave (
        output req_relock, pll_locked,
        input  pll_rst, sys_reset_n, ready, fault,
        input  retry_cnt, state_dbg, lock_loss_cnt
    );

endinterface

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
// Ports: refclk, rst_n (sync, active low), d (async in), q (synchronized out).
module pll_lock_sync #(
    parameter int STAGES = 2
) (
    input  logic refclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    import pll_sup_pkg::*;

    logic [STAGES-1:0] chain;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for lock with timeout and
// retry, demands a clean settle window, then releases the core reset.
// Ports: refclk, rst_n (sync, active low), bus (pll_sup_if.master).
// Build option: PLL_SUP_STATS_EN enables the saturating lock_loss_cnt.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 32,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic         refclk,
    input  logic         rst_n,
    pll_sup_if.master    bus
);

    localparam int TW = tmr_w(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SET_DONE = TW'(SETTLE_CYCLES);
    localparam logic [1:0]    RETRY_MX = 2'(MAX_RETRIES);

    pll_sup_state_t state, state_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic [1:0]     retry, retry_nxt, retry_inc;
    logic           locked_s;
    logic           loss_evt;
    logic           pll_rst_q, sys_n_q, ready_q, fault_q;

    pll_lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .refclk (refclk),
        .rst_n  (rst_n),
        .d      (bus.pll_locked),
        .q      (locked_s)
    );

    assign retry_inc = retry + 2'd1;

    // Timer restarts on every state entry; it never free-runs past a terminal count.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        retry_nxt = retry;
        loss_evt  = 1'b0;
        if (bus.req_relock) begin
            state_nxt = ST_PLLRST;
            timer_nxt = '0;
            retry_nxt = '0;
        end else begin
            unique case (state)
                ST_PLLRST: begin
                    if (timer == RST_LAST) begin
                        state_nxt = ST_WAIT;
                        timer_nxt = '0;
                    end
                end
                ST_WAIT: begin
                    if (locked_s) begin
                        state_nxt = ST_SETTLE;
                        timer_nxt = '0;
                    end else if (timer == TO_LAST) begin
                        retry_nxt = retry_inc;
                        timer_nxt = '0;
                        state_nxt = (retry_inc == RETRY_MX) ? ST_FAULT
                                                            : ST_PLLRST;
                    end
                end
                ST_SETTLE: begin
                    if (!locked_s) begin
                        state_nxt = ST_WAIT;
                        timer_nxt = '0;
                    end else if (timer == SET_DONE) begin
                        state_nxt = ST_RUN;
                        timer_nxt = '0;
                        retry_nxt = '0;
                    end
                end
                ST_RUN: begin
                    timer_nxt = '0;
                    retry_nxt = '0;
                    if (!locked_s) begin
                        state_nxt = ST_PLLRST;
                        loss_evt  = 1'b1;
                    end
                end
                ST_FAULT: begin
                    timer_nxt = '0;
                end
                default: begin
                    state_nxt = ST_PLLRST;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they track state_dbg.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state     <= ST_PLLRST;
            timer     <= '0;
            retry     <= '0;
            pll_rst_q <= 1'b1;
            sys_n_q   <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            retry     <= retry_nxt;
            pll_rst_q <= (state_nxt == ST_PLLRST) ||
                         (state_nxt == ST_FAULT);
            sys_n_q   <= (state_nxt == ST_RUN);
            ready_q   <= (state_nxt == ST_RUN);
            fault_q   <= (state_nxt == ST_FAULT);
        end
    end

`ifdef PLL_SUP_STATS_EN
    logic [7:0] loss_cnt;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (loss_evt && (loss_cnt != 8'hff)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = loss_cnt;
`else
    logic unused_loss;
    assign unused_loss       = loss_evt;
    assign bus.lock_loss_cnt = 8'd0;
`endif

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_reset_n = sys_n_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.retry_cnt   = retry;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
// Expected values are hand-derived edge counts from each stimulus point.
module tb_pll_lock_supervisor;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

`ifdef PLL_SUP_STATS_EN
    localparam logic [7:0] LL_EXP = 8'd1;
`else
    localparam logic [7:0] LL_EXP = 8'd0;
`endif

    pll_sup_if bus_i ();

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (16),
        .SETTLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .SYNC_STAGES   (2)
    ) dut (
        .refclk (clk),
        .rst_n  (rst_n),
        .bus    (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_state"}, 32'(bus_i.state_dbg), 0);
        check({tag, "_pllrst"}, 32'(bus_i.pll_rst), 1);
        check({tag, "_sysn"}, 32'(bus_i.sys_reset_n), 0);
        check({tag, "_ready"}, 32'(bus_i.ready), 0);
        check({tag, "_fault"}, 32'(bus_i.fault), 0);
        check({tag, "_retry"}, 32'(bus_i.retry_cnt), 0);
        check({tag, "_ll"}, 32'(bus_i.lock_loss_cnt), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus_i.req_relock = 1'b0;
        bus_i.pll_locked = 1'b0;

        // Reset state
        tick(3);
        chk_reset_vals("rst");

        // Clean start: 4-cycle pll_rst, lock two cycles later
        rst_n = 1'b1;
        tick(3);
        check("cs_pllrst_hi", 32'(bus_i.pll_rst), 1);
        tick(1);
        check("cs_pllrst_lo", 32'(bus_i.pll_rst), 0);
        check("cs_wait", 32'(bus_i.state_dbg), 1);
        tick(2);
        bus_i.pll_locked = 1'b1;
        tick(11);
        check("cs_ready_early", 32'(bus_i.ready), 0);
        check("cs_settle", 32'(bus_i.state_dbg), 2);
        tick(1);
        check("cs_ready", 32'(bus_i.ready), 1);
        check("cs_sysn", 32'(bus_i.sys_reset_n), 1);
        check("cs_retry", 32'(bus_i.retry_cnt), 0);
        check("cs_run", 32'(bus_i.state_dbg), 3);

        // Lock loss in RUN
        bus_i.pll_locked = 1'b0;
        tick(2);
        check("ll_sysn_hold", 32'(bus_i.sys_reset_n), 1);
        tick(1);
        check("ll_sysn", 32'(bus_i.sys_reset_n), 0);
        check("ll_state", 32'(bus_i.state_dbg), 0);
        check("ll_ready", 32'(bus_i.ready), 0);
        check("ll_cnt", 32'(bus_i.lock_loss_cnt), 32'(LL_EXP));
        tick(3);
        check("ll_pllrst_hi", 32'(bus_i.pll_rst), 1);
        tick(1);
        check("ll_pllrst_lo", 32'(bus_i.pll_rst), 0);
        bus_i.pll_locked = 1'b1;
        tick(11);
        check("ll_ready_early", 32'(bus_i.ready), 0);
        tick(1);
        check("ll_recover", 32'(bus_i.ready), 1);

        // Relock from RUN, first attempt times out, then settle glitch
        bus_i.req_relock = 1'b1;
        bus_i.pll_locked = 1'b0;
        tick(1);
        bus_i.req_relock = 1'b0;
        check("rl_state", 32'(bus_i.state_dbg), 0);
        check("rl_ll_hold", 32'(bus_i.lock_loss_cnt), 32'(LL_EXP));
        tick(19);
        check("gl_wait", 32'(bus_i.state_dbg), 1);
        tick(1);
        check("gl_retry1", 32'(bus_i.retry_cnt), 1);
        check("gl_pllrst", 32'(bus_i.pll_rst), 1);
        tick(2);
        bus_i.pll_locked = 1'b1;
        tick(3);
        check("gl_settle", 32'(bus_i.state_dbg), 2);
        tick(3);
        bus_i.pll_locked = 1'b0;
        tick(1);
        bus_i.pll_locked = 1'b1;
        tick(2);
        check("gl_back_wait", 32'(bus_i.state_dbg), 1);
        check("gl_retry_keep", 32'(bus_i.retry_cnt), 1);
        tick(9);
        check("gl_ready_early", 32'(bus_i.ready), 0);
        tick(1);
        check("gl_ready", 32'(bus_i.ready), 1);
        check("gl_retry_clr", 32'(bus_i.retry_cnt), 0);

        // Never locks: three attempts then FAULT
        bus_i.req_relock = 1'b1;
        bus_i.pll_locked = 1'b0;
        tick(1);
        bus_i.req_relock = 1'b0;
        tick(19);
        check("nl_retry0", 32'(bus_i.retry_cnt), 0);
        tick(1);
        check("nl_retry1", 32'(bus_i.retry_cnt), 1);
        check("nl_st0", 32'(bus_i.state_dbg), 0);
        tick(3);
        check("nl_pulse_hi", 32'(bus_i.pll_rst), 1);
        tick(1);
        check("nl_pulse_lo", 32'(bus_i.pll_rst), 0);
        tick(16);
        check("nl_retry2", 32'(bus_i.retry_cnt), 2);
        tick(20);
        check("nl_fault", 32'(bus_i.fault), 1);
        check("nl_st4", 32'(bus_i.state_dbg), 4);
        check("nl_retry3", 32'(bus_i.retry_cnt), 3);
        check("nl_pllrst", 32'(bus_i.pll_rst), 1);
        check("nl_sysn", 32'(bus_i.sys_reset_n), 0);
        tick(50);
        check("nl_fault_hold", 32'(bus_i.fault), 1);
        check("nl_pllrst_hold", 32'(bus_i.pll_rst), 1);

        // Relock out of FAULT, then relock on attempt-3 timeout cycle
        bus_i.req_relock = 1'b1;
        tick(1);
        bus_i.req_relock = 1'b0;
        check("fx_state", 32'(bus_i.state_dbg), 0);
        check("fx_fault", 32'(bus_i.fault), 0);
        check("fx_retry", 32'(bus_i.retry_cnt), 0);
        tick(59);
        check("pr_wait", 32'(bus_i.state_dbg), 1);
        check("pr_retry2", 32'(bus_i.retry_cnt), 2);
        bus_i.req_relock = 1'b1;
        tick(1);
        bus_i.req_relock = 1'b0;
        check("pr_state", 32'(bus_i.state_dbg), 0);
        check("pr_retry", 32'(bus_i.retry_cnt), 0);
        check("pr_fault", 32'(bus_i.fault), 0);

        // Reset mid-SETTLE
        bus_i.pll_locked = 1'b1;
        tick(5);
        check("ms_settle", 32'(bus_i.state_dbg), 2);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk_reset_vals("ms");
        rst_n = 1'b1;
        tick(13);
        check("ms_ready_early", 32'(bus_i.ready), 0);
        tick(1);
        check("ms_ready", 32'(bus_i.ready), 1);
        check("ms_sysn", 32'(bus_i.sys_reset_n), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
